// File: rtl/xor_bitwise_pkg.sv
// Shared constants and width helpers for the bitwise XOR / Hamming-distance block.
package xor_bitwise_pkg;

    // Operand width used when the instantiating code does not override it.
    localparam int DEFAULT_WIDTH = 16;

    // Width needed to hold any count from 0 up to and including w.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Number of adder levels in a binary tree that reduces w single-bit leaves.
    function automatic int tree_levels(input int w);
        int lv;
        if (w <= 1) begin
            lv = 0;
        end else begin
            lv = $clog2(w);
        end
        return lv;
    endfunction

    // Odd parity of a 64-bit word; handy when protecting operand buses.
    function automatic logic odd_parity64(input logic [63:0] v);
        return ^v;
    endfunction

endpackage : xor_bitwise_pkg

// File: rtl/xor_bitwise_popcount.sv
// Combinational population count built as a balanced binary adder tree.
// The leaf level is padded to a power of two with zero leaves so every
// internal level halves cleanly; each level lives in its own generate scope.
module popcount
    import xor_bitwise_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]              in_vec,
    output logic [count_width(WIDTH)-1:0] count
);

    localparam int CW     = count_width(WIDTH);
    localparam int LEVELS = tree_levels(WIDTH);
    localparam int LEAVES = 1 << LEVELS;

    genvar l, i;
    generate
        for (l = 0; l <= LEVELS; l++) begin : g_lvl
            localparam int N = LEAVES >> l;
            logic [CW-1:0] sum_s [N];

            if (l == 0) begin : g_leaf
                for (i = 0; i < N; i++) begin : g_bit
                    if (i < WIDTH) begin : g_real
                        assign sum_s[i] = CW'(in_vec[i]);
                    end else begin : g_pad
                        assign sum_s[i] = {CW{1'b0}};
                    end
                end
            end else begin : g_add
                // Each node sums two children; the root can never exceed WIDTH,
                // so CW bits are enough at every level.
                for (i = 0; i < N; i++) begin : g_node
                    assign sum_s[i] = g_lvl[l-1].sum_s[2*i] + g_lvl[l-1].sum_s[2*i+1];
                end
            end
        end
    endgenerate

    assign count = g_lvl[LEVELS].sum_s[0];

endmodule : popcount

// File: rtl/xor_bitwise.sv
// Bitwise XOR of two operands with a combinational result and a registered
// copy, plus the registered Hamming distance and an equality flag.
module xor_bitwise
    import xor_bitwise_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic [WIDTH-1:0]              f,
    output logic [WIDTH-1:0]              f_q,
    output logic [count_width(WIDTH)-1:0] diff_cnt_q,
    output logic                          equal_q
);

    localparam int CW = count_width(WIDTH);

    logic [WIDTH-1:0] f_s;
    logic [CW-1:0]    cnt_s;
    logic             equal_s;

    // Pure combinational XOR; reset and clock have no influence here.
    assign f_s = a ^ b;
    assign f   = f_s;

    popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .in_vec (f_s),
        .count  (cnt_s)
    );

    // Derived from the count so equal_q always matches (diff_cnt_q == 0).
    assign equal_s = (cnt_s == {CW{1'b0}});

    // Registered outputs: all three load together; reset gives a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q        <= {WIDTH{1'b0}};
            diff_cnt_q <= {CW{1'b0}};
            equal_q    <= 1'b1;
        end else begin
            f_q        <= f_s;
            diff_cnt_q <= cnt_s;
            equal_q    <= equal_s;
        end
    end

endmodule : xor_bitwise

// File: tb/tb_xor_bitwise.sv
// Directed table plus reset sequences and a randomised run for xor_bitwise.
module tb_xor_bitwise;

    localparam int W  = 16;
    localparam int CW = 5;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  f;
    logic [W-1:0]  f_q;
    logic [CW-1:0] diff_cnt_q;
    logic          equal_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  exp_f;
        logic [CW-1:0] exp_cnt;
        logic          exp_eq;
    } vec_t;

    vec_t vecs [11];

    xor_bitwise #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .f          (f),
        .f_q        (f_q),
        .diff_cnt_q (diff_cnt_q),
        .equal_q    (equal_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [W-1:0] prev;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0]  = '{16'h0000, 16'h0000, 16'h0000, 5'd0,  1'b1};
        vecs[1]  = '{16'hAAAA, 16'hCCCC, 16'h6666, 5'd8,  1'b0};
        vecs[2]  = '{16'hFFFF, 16'h0000, 16'hFFFF, 5'd16, 1'b0};
        vecs[3]  = '{16'h0000, 16'hFFFF, 16'hFFFF, 5'd16, 1'b0};
        vecs[4]  = '{16'hF0F0, 16'hAAAA, 16'h5A5A, 5'd8,  1'b0};
        vecs[5]  = '{16'h0F0F, 16'hF0F0, 16'hFFFF, 5'd16, 1'b0};
        vecs[6]  = '{16'h1234, 16'h1234, 16'h0000, 5'd0,  1'b1};
        vecs[7]  = '{16'h0001, 16'h0000, 16'h0001, 5'd1,  1'b0};
        vecs[8]  = '{16'h8000, 16'h0000, 16'h8000, 5'd1,  1'b0};
        vecs[9]  = '{16'h1234, 16'h0000, 16'h1234, 5'd5,  1'b0};
        vecs[10] = '{16'hFFFE, 16'h0000, 16'hFFFE, 5'd15, 1'b0};

        // Power-on reset, asserted before the first clock edge.
        rst_n = 1'b1;
        a     = 16'h1234;
        b     = 16'h0000;
        #2 rst_n = 1'b0;
        #1;
        chk("por_f_q",   64'(f_q),        64'h0);
        chk("por_cnt",   64'(diff_cnt_q), 64'h0);
        chk("por_eq",    64'(equal_q),    64'h1);
        chk("por_f",     64'(f),          64'h1234);
        @(posedge clk); #1;
        chk("por_hold_f_q", 64'(f_q),     64'h0);
        @(negedge clk);
        a     = 16'h0000;
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            a = vecs[i].a;
            b = vecs[i].b;
            #1;
            chk($sformatf("tbl%0d_f", i), 64'(f), 64'(vecs[i].exp_f));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_f_q", i), 64'(f_q),        64'(vecs[i].exp_f));
            chk($sformatf("tbl%0d_cnt", i), 64'(diff_cnt_q), 64'(vecs[i].exp_cnt));
            chk($sformatf("tbl%0d_eq", i),  64'(equal_q),    64'(vecs[i].exp_eq));
        end

        // Reset asserted mid-cycle after a non-zero load.
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'h0000;
        @(posedge clk); #1;
        chk("mid_pre_f_q", 64'(f_q), 64'hFFFF);
        #2;
        a     = 16'h1234;
        rst_n = 1'b0;
        #1;
        chk("mid_f_q", 64'(f_q),        64'h0);
        chk("mid_cnt", 64'(diff_cnt_q), 64'h0);
        chk("mid_eq",  64'(equal_q),    64'h1);
        chk("mid_f",   64'(f),          64'h1234);
        @(posedge clk); #1;
        chk("mid_hold_f_q", 64'(f_q), 64'h0);
        chk("mid_hold_f",   64'(f),   64'h1234);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_before_edge_f_q", 64'(f_q), 64'h0);
        @(posedge clk); #1;
        chk("rel_f_q", 64'(f_q),        64'h1234);
        chk("rel_cnt", 64'(diff_cnt_q), 64'd5);
        chk("rel_eq",  64'(equal_q),    64'h0);

        // Randomised run; about one cycle in eight uses equal operands.
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            ra = W'($urandom);
            rb = ($urandom_range(7, 0) == 0) ? ra : W'($urandom);
            a  = ra;
            b  = rb;
            #1;
            chk("rnd_f", 64'(f), 64'(ra ^ rb));
            prev = ra ^ rb;
            @(posedge clk); #1;
            chk("rnd_f_q", 64'(f_q),        64'(prev));
            chk("rnd_cnt", 64'(diff_cnt_q), 64'($countones(prev)));
            chk("rnd_eq",  64'(equal_q),    64'(prev == 16'h0000));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_xor_bitwise
